// File: rtl/function_row_sequencer.sv
// Streams NUM_ROWS generator rows, each followed by NUM_SHIFTS-1 left-rotated copies, on a valid/ready port.
// Define FGEN_LOAD_EN to make the row table writable through the wr_* port (default: constant ROM).
module function_row_sequencer #(
  parameter int K_N        = 256,
  parameter int NUM_ROWS   = 4,
  parameter int NUM_SHIFTS = 16,
  parameter int SHIFT_STEP = 1,
  parameter int ADDR_W     = 2,
  parameter int SHIFT_W    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
`ifdef FGEN_LOAD_EN
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [K_N-1:0]     wr_data,
  output logic               wr_err,
`endif
  output logic [K_N-1:0]     f_out,
  output logic               f_valid,
  input  logic               f_ready,
  output logic [ADDR_W-1:0]  f_row,
  output logic [SHIFT_W-1:0] f_shift,
  output logic               f_last,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EMIT, S_DONE} state_t;

  state_t               r_state, w_next;
  logic [K_N-1:0]       r_out;
  logic [ADDR_W-1:0]    r_row;
  logic [SHIFT_W-1:0]   r_shift;
  logic [K_N-1:0]       w_row_data;
  logic                 w_accept, w_last_shift, w_last_row;

  function automatic logic [K_N-1:0] default_row(input int unsigned idx);
    logic [255:0] c;
    case (idx)
      0:       c = 256'h3808686AD4706057D160CE6DD1FBDC49BC2C9D9D15C639207F397CCCB46CD901;
      1:       c = 256'h75DCFBBD645F404EEA309F6104F99C058C59D4E975A24DE11CC5A3079B559A92;
      2:       c = 256'h6709C0EB57ECCD19C6C16A91FB816854314972D239BC37824D749BFB3A13ABA5;
      3:       c = 256'hF657015660A9458EF3551EF7B7AD4AB1669250F9716DCD8669F5E8D2743414DA;
      default: c = '0;
    endcase
    return K_N'(c);
  endfunction

  function automatic logic [K_N-1:0] rotl(input logic [K_N-1:0] x);
    return {x[K_N-1-SHIFT_STEP:0], x[K_N-1:K_N-SHIFT_STEP]};
  endfunction

`ifdef FGEN_LOAD_EN
  logic [K_N-1:0] r_table [NUM_ROWS];
  logic           r_wr_err;

  // Writes only land while idle so a running sequence never sees a half-updated table.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_ROWS; i++) r_table[i] <= default_row(i);
      r_wr_err <= 1'b0;
    end else begin
      r_wr_err <= 1'b0;
      if (wr_en) begin
        if (r_state == S_IDLE && 32'(wr_addr) < NUM_ROWS) r_table[wr_addr] <= wr_data;
        else                                               r_wr_err <= 1'b1;
      end
    end
  end

  assign wr_err     = r_wr_err;
  assign w_row_data = r_table[r_row];
`else
  assign w_row_data = default_row(32'(r_row));
`endif

  assign w_accept     = f_valid & f_ready;
  assign w_last_shift = (r_shift == SHIFT_W'(NUM_SHIFTS - 1));
  assign w_last_row   = (r_row == ADDR_W'(NUM_ROWS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_next = S_LOAD;
      S_LOAD: w_next = S_EMIT;
      S_EMIT: if (w_accept && w_last_shift) w_next = w_last_row ? S_DONE : S_LOAD;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (abort) w_next = S_IDLE;
  end

  always_comb begin
    f_valid = (r_state == S_EMIT);
    busy    = (r_state != S_IDLE);
    done    = (r_state == S_DONE);
    f_last  = f_valid & w_last_row & w_last_shift;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out   <= '0;
      r_row   <= '0;
      r_shift <= '0;
    end else if (abort) begin
      r_row   <= '0;
      r_shift <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_row   <= '0;
          r_shift <= '0;
        end
        S_LOAD: begin
          r_out   <= w_row_data;
          r_shift <= '0;
        end
        S_EMIT: if (w_accept) begin
          if (!w_last_shift) begin
            r_out   <= rotl(r_out);
            r_shift <= r_shift + 1'b1;
          end else if (!w_last_row) begin
            r_row <= r_row + 1'b1;
          end
        end
        S_DONE: begin
          r_row   <= '0;
          r_shift <= '0;
        end
        default: ;
      endcase
    end
  end

  assign f_out   = r_out;
  assign f_row   = r_row;
  assign f_shift = r_shift;

endmodule
